// File: rtl/idt_cfg_pkg.sv
// idt_cfg_pkg: shared types, word layout and boot default for the IDT clock-synthesizer scheduler
package idt_cfg_pkg;
  localparam int CFG_W = 24;
  localparam logic [CFG_W-1:0] BOOT_CFG_DEF = 24'h36A7EB;
  localparam int C_OFS   = 22;
  localparam int TTL_OFS = 21;
  localparam int F_OFS   = 19;
  localparam int S_OFS   = 16;
  localparam int V_OFS   = 7;
  localparam int R_OFS   = 0;
  typedef enum logic [2:0] {ST_BOOT, ST_IDLE, ST_SHIFT, ST_STROBE, ST_LOCK, ST_DONE} state_t;
endpackage

// File: rtl/idt_cfg_sched_if.sv
// idt_cfg_sched_if: requester-side bus of the synthesizer scheduler
interface idt_cfg_sched_if;
  import idt_cfg_pkg::*;
  logic [1:0] req;
  logic [CFG_W-1:0] cfg0;
  logic [CFG_W-1:0] cfg1;
  logic [1:0] grant;
  logic [1:0] ack;
  logic busy;
  logic [CFG_W-1:0] cur_cfg;
  logic clk_ready;
  modport master (output req, cfg0, cfg1, input grant, ack, busy, cur_cfg, clk_ready);
  modport slave (input req, cfg0, cfg1, output grant, ack, busy, cur_cfg, clk_ready);
endinterface

// File: rtl/idt_ser_shift.sv
// idt_ser_shift: serializes one config word MSB first on sclk/data, then pulses the load strobe
module idt_ser_shift
  import idt_cfg_pkg::*;
#(
  parameter int SCLK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CFG_W-1:0] i_word,
  output logic             o_sclk,
  output logic             o_data,
  output logic             o_strobe,
  output logic             o_shift_end,
  output logic             o_done
);
  localparam int DW = $clog2(2 * SCLK_DIV);
  localparam int BW = $clog2(CFG_W);
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [CFG_W-1:0] r_sr;
  logic r_act, r_stb, w_wrap;
  assign w_wrap = r_div == DW'(2 * SCLK_DIV - 1);
  assign o_shift_end = r_act & w_wrap & (r_bit == BW'(CFG_W - 1));
  assign o_done = r_stb & w_wrap;
  assign o_sclk = r_act & (r_div >= DW'(SCLK_DIV));
  assign o_data = r_act & r_sr[CFG_W-1];
  assign o_strobe = r_stb;
  // one divider paces both the bit cells and the strobe pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_bit <= '0;
      r_sr  <= '0;
      r_act <= 1'b0;
      r_stb <= 1'b0;
    end else if (i_start) begin
      r_div <= '0;
      r_bit <= '0;
      r_sr  <= i_word;
      r_act <= 1'b1;
      r_stb <= 1'b0;
    end else if (r_act | r_stb) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap && r_act) begin
        r_sr  <= {r_sr[CFG_W-2:0], 1'b0};
        r_bit <= r_bit + 1'b1;
      end
      if (o_shift_end) begin
        r_act <= 1'b0;
        r_stb <= 1'b1;
      end
      if (o_done) r_stb <= 1'b0;
    end
  end
endmodule

// File: rtl/idt_cfg_sched.sv
// idt_cfg_sched: boots, then round-robin programs the IDT synthesizer for two requesters.
// IDT_CFG_SKIP_SAME_EN: a grant whose word is already locked in is acked without reprogramming.
module idt_cfg_sched
  import idt_cfg_pkg::*;
#(
  parameter logic [CFG_W-1:0] BOOT_CFG    = BOOT_CFG_DEF,
  parameter int               SCLK_DIV    = 1,
  parameter int               LOCK_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  idt_cfg_sched_if.slave    bus,
  output logic              o_idt_sclk,
  output logic              o_idt_data,
  output logic              o_idt_strobe
);
  localparam int LW = $clog2(LOCK_CYCLES) > 0 ? $clog2(LOCK_CYCLES) : 1;
  state_t r_state, w_next;
  logic [CFG_W-1:0] r_word, r_cur, w_pick_cfg;
  logic [1:0] r_grant, w_pick;
  logic [LW-1:0] r_lock;
  logic r_last, r_rdy, w_go, w_skip, w_start, w_shift_end, w_done, w_lock_end;
  assign w_go = |bus.req;
  assign w_pick = &bus.req ? (r_last ? 2'b01 : 2'b10) : bus.req;
  assign w_pick_cfg = w_pick[1] ? bus.cfg1 : bus.cfg0;
`ifdef IDT_CFG_SKIP_SAME_EN
  assign w_skip = r_rdy && (w_pick_cfg == r_cur);
`else
  assign w_skip = 1'b0;
`endif
  assign w_lock_end = r_lock == LW'(LOCK_CYCLES - 1);
  assign w_start = (r_state == ST_BOOT) || (r_state == ST_IDLE && w_next == ST_SHIFT);
  idt_ser_shift #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(w_start),
    .i_word(r_state == ST_BOOT ? BOOT_CFG : w_pick_cfg),
    .o_sclk(o_idt_sclk),
    .o_data(o_idt_data),
    .o_strobe(o_idt_strobe),
    .o_shift_end(w_shift_end),
    .o_done(w_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_BOOT:   w_next = ST_SHIFT;
      ST_IDLE:   w_next = !w_go ? ST_IDLE : (w_skip ? ST_DONE : ST_SHIFT);
      ST_SHIFT:  w_next = w_shift_end ? ST_STROBE : ST_SHIFT;
      ST_STROBE: w_next = w_done ? ST_LOCK : ST_STROBE;
      ST_LOCK:   w_next = w_lock_end ? ST_DONE : ST_LOCK;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_BOOT;
    endcase
  end
  always_comb begin
    bus.ack = r_state == ST_DONE ? r_grant : 2'b00;
    bus.busy = r_state inside {ST_SHIFT, ST_STROBE, ST_LOCK, ST_DONE};
  end
  assign bus.grant = r_grant;
  assign bus.cur_cfg = r_cur;
  assign bus.clk_ready = r_rdy;
  // r_last remembers the most recent owner so a tie goes to the other requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_cur   <= '0;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_rdy   <= 1'b0;
      r_lock  <= '0;
    end else begin
      r_lock <= r_state == ST_LOCK ? r_lock + 1'b1 : '0;
      if (r_state == ST_BOOT) r_word <= BOOT_CFG;
      if (r_state == ST_IDLE && w_go) begin
        r_word  <= w_pick_cfg;
        r_grant <= w_pick;
        r_last  <= w_pick[1];
      end
      if (r_state == ST_DONE) begin
        r_grant <= 2'b00;
        r_cur   <= r_word;
        r_rdy   <= 1'b1;
      end
      if (w_start) r_rdy <= 1'b0;
    end
  end
endmodule
